axis_pkt_sink_mon: RTL and testbench

- Receive-side endpoint for the pipeline's 512-bit AXI-Stream output, i.e. the consumer of rmt_wrapper's m_axis_* interface.
- Provides programmable tready backpressure and checks packet framing and tkeep legality.
- Counts packets, beats and bytes, and latches the first beat and tuser of the most recent good packet.
- Used in simulation benches and as an on-chip debug tap in front of the output port.

---
 rtl/axis_mon_pkg.sv | 34 +++
 rtl/axis_stall_gen.sv | 42 ++++
 rtl/axis_pkt_sink_mon.sv | 217 +++++++++++++++++++++
 tb/tb_axis_pkt_sink_mon.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_mon_pkg
// Description : Shared types, error-bit indices and helpers for the
//               AXI-Stream packet sink monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_DROP   = 2'd2
    } mon_state_t;

    localparam int unsigned c_DATA_WIDTH = 512;
    localparam int unsigned KEEP_W       = c_DATA_WIDTH / 8;

    localparam int unsigned c_ERR_NONCONTIG = 0;
    localparam int unsigned c_ERR_SHORT     = 1;
    localparam int unsigned c_ERR_ZERO      = 2;
    localparam int unsigned c_ERR_OVERSIZE  = 3;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_stall_gen.sv
`default_nettype none
// ============================================================================
// Module      : axis_stall_gen
// Description : Free-running phase counter producing periodic tready stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_stall_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_stall_en,
    input  logic [7:0] i_stall_period,
    input  logic [7:0] i_stall_len,
    output logic       o_tready
);

    logic [7:0] r_phase;
    logic       r_tready;
    logic       w_stall_active;

    assign w_stall_active = i_stall_en && (i_stall_period > 8'd1) && (r_phase < i_stall_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= 8'd0;
            r_tready <= 1'b1;
        end else begin
            if (i_clear || (i_stall_period <= 8'd1)) begin
                r_phase <= 8'd0;
            end else if (r_phase >= (i_stall_period - 8'd1)) begin
                r_phase <= 8'd0;
            end else begin
                r_phase <= r_phase + 8'd1;
            end
            r_tready <= !w_stall_active;
        end
    end

    assign o_tready = r_tready;

endmodule
`default_nettype wire

// File: rtl/axis_pkt_sink_mon.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_sink_mon
// Description : AXI-Stream receive endpoint with backpressure, framing and
//               tkeep checks, traffic counters and last-good-packet capture.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_sink_mon
    import axis_mon_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned MAX_BEATS            = 64,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              stall_en,
    input  logic [7:0]                        stall_period,
    input  logic [7:0]                        stall_len,
    input  logic                              clear,
    output logic                              pkt_done,
    output logic [15:0]                       pkt_bytes,
    output logic [CNT_WIDTH-1:0]              pkt_cnt,
    output logic [CNT_WIDTH-1:0]              beat_cnt,
    output logic [47:0]                       byte_cnt,
    output logic [CNT_WIDTH-1:0]              err_cnt,
    output logic [3:0]                        err_flags,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    first_beat,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   first_tuser
);

    localparam int unsigned c_BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [c_BEAT_W-1:0] c_MAX_BEATS = c_BEAT_W'(MAX_BEATS);

    mon_state_t                       r_state;
    mon_state_t                       w_state_nx;
    logic [c_BEAT_W-1:0]              r_beats;
    logic [c_BEAT_W-1:0]              w_beats_nx;
    logic [15:0]                      r_bytes_acc;
    logic [15:0]                      w_bytes_nx;
    logic                             r_taint;
    logic                             w_taint_nx;
    logic                             w_finish;
    logic                             w_drop_entry;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   r_shadow_data;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  r_shadow_user;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   w_first_data;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  w_first_user;

    logic                             w_tready;
    logic                             w_xfer;
    logic [6:0]                       w_keep_pop;
    logic [3:0]                       w_beat_err;
    logic [16:0]                      w_bytes_sum;
    logic [48:0]                      w_byte_cnt_sum;

    logic                             r_done;
    logic [15:0]                      r_pkt_bytes;
    logic [CNT_WIDTH-1:0]             r_pkt_cnt;
    logic [CNT_WIDTH-1:0]             r_beat_cnt;
    logic [47:0]                      r_byte_cnt;
    logic [CNT_WIDTH-1:0]             r_err_cnt;
    logic [3:0]                       r_err_flags;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   r_first_beat;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  r_first_tuser;

    axis_stall_gen u_stall_gen (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (clear),
        .i_stall_en     (stall_en),
        .i_stall_period (stall_period),
        .i_stall_len    (stall_len),
        .o_tready       (w_tready)
    );

    assign w_xfer         = s_axis_tvalid && w_tready;
    assign w_keep_pop     = popcount64(s_axis_tkeep);
    assign w_bytes_sum    = {1'b0, r_bytes_acc} + 17'(w_keep_pop);
    assign w_byte_cnt_sum = {1'b0, r_byte_cnt} + 49'(w_keep_pop);

    // A legal tkeep is a run of ones from bit 0, so adding 1 clears every set bit
    always_comb begin
        w_beat_err                  = 4'b0000;
        w_beat_err[c_ERR_NONCONTIG] = |(s_axis_tkeep & (s_axis_tkeep + 1'b1));
        w_beat_err[c_ERR_SHORT]     = !s_axis_tlast && !(&s_axis_tkeep);
        w_beat_err[c_ERR_ZERO]      = (s_axis_tkeep == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_beats_nx   = r_beats;
        w_bytes_nx   = r_bytes_acc;
        w_taint_nx   = r_taint;
        w_finish     = 1'b0;
        w_drop_entry = 1'b0;
        if (w_xfer) begin
            case (r_state)
                ST_IDLE, ST_IN_PKT: begin
                    if (r_state == ST_IDLE) begin
                        w_beats_nx = c_BEAT_W'(1);
                        w_bytes_nx = 16'(w_keep_pop);
                        w_taint_nx = |w_beat_err;
                    end else begin
                        w_beats_nx = r_beats + 1'b1;
                        w_bytes_nx = w_bytes_sum[16] ? 16'hFFFF : w_bytes_sum[15:0];
                        w_taint_nx = r_taint || (|w_beat_err);
                    end
                    if (s_axis_tlast) begin
                        w_finish   = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else if (w_beats_nx >= c_MAX_BEATS) begin
                        w_drop_entry = 1'b1;
                        w_state_nx   = ST_DROP;
                    end else begin
                        w_state_nx = ST_IN_PKT;
                    end
                end
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        w_state_nx = ST_IDLE;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    // A single-beat packet has no shadow yet, so take its first beat straight from the bus
    assign w_first_data = (r_state == ST_IDLE) ? s_axis_tdata : r_shadow_data;
    assign w_first_user = (r_state == ST_IDLE) ? s_axis_tuser : r_shadow_user;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beats       <= '0;
            r_bytes_acc   <= '0;
            r_taint       <= 1'b0;
            r_shadow_data <= '0;
            r_shadow_user <= '0;
            r_done        <= 1'b0;
            r_pkt_bytes   <= '0;
            r_first_beat  <= '0;
            r_first_tuser <= '0;
        end else begin
            r_done <= w_finish;
            if (w_xfer) begin
                r_beats     <= w_beats_nx;
                r_bytes_acc <= w_bytes_nx;
                r_taint     <= w_taint_nx;
                if (r_state == ST_IDLE) begin
                    r_shadow_data <= s_axis_tdata;
                    r_shadow_user <= s_axis_tuser;
                end
            end
            if (w_finish) begin
                r_pkt_bytes <= w_bytes_nx;
                if (!w_taint_nx) begin
                    r_first_beat  <= w_first_data;
                    r_first_tuser <= w_first_user;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_pkt_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_flags <= '0;
        end else begin
            if (w_xfer) begin
                if (r_beat_cnt != '1) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                r_byte_cnt  <= w_byte_cnt_sum[48] ? '1 : w_byte_cnt_sum[47:0];
                r_err_flags <= r_err_flags | w_beat_err |
                               (w_drop_entry ? (4'b0001 << c_ERR_OVERSIZE) : 4'b0000);
            end
            if (w_finish && !w_taint_nx && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
            if (((w_finish && w_taint_nx) || w_drop_entry) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign pkt_done      = r_done;
    assign pkt_bytes     = r_pkt_bytes;
    assign pkt_cnt       = r_pkt_cnt;
    assign beat_cnt      = r_beat_cnt;
    assign byte_cnt      = r_byte_cnt;
    assign err_cnt       = r_err_cnt;
    assign err_flags     = r_err_flags;
    assign first_beat    = r_first_beat;
    assign first_tuser   = r_first_tuser;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_sink_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_sink_mon
// Description : Directed self-checking bench for axis_pkt_sink_mon.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_sink_mon;

    logic          clk = 1'b0;
    logic          rst;
    logic [511:0]  s_axis_tdata;
    logic [63:0]   s_axis_tkeep;
    logic [127:0]  s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          stall_en;
    logic [7:0]    stall_period;
    logic [7:0]    stall_len;
    logic          clear;
    logic          pkt_done;
    logic [15:0]   pkt_bytes;
    logic [31:0]   pkt_cnt;
    logic [31:0]   beat_cnt;
    logic [47:0]   byte_cnt;
    logic [31:0]   err_cnt;
    logic [3:0]    err_flags;
    logic [511:0]  first_beat;
    logic [127:0]  first_tuser;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    axis_pkt_sink_mon dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .stall_en      (stall_en),
        .stall_period  (stall_period),
        .stall_len     (stall_len),
        .clear         (clear),
        .pkt_done      (pkt_done),
        .pkt_bytes     (pkt_bytes),
        .pkt_cnt       (pkt_cnt),
        .beat_cnt      (beat_cnt),
        .byte_cnt      (byte_cnt),
        .err_cnt       (err_cnt),
        .err_flags     (err_flags),
        .first_beat    (first_beat),
        .first_tuser   (first_tuser)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) done_seen <= 0;
        else if (pkt_done) done_seen <= done_seen + 1;
    end

    function automatic logic [511:0] mk(input int s);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(s) ^ (32'(i) << 24);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cyc(n);
    endtask

    // Presents one beat and holds it until a handshake; tvalid stays high afterwards
    task automatic send(input logic [511:0] d, input logic [63:0] k,
                        input logic [127:0] u, input logic l);
        bit acc;
        int n;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        do begin
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++;
            bad++;
            $error("FAIL send_timeout: observed=no_handshake expected=handshake");
        end
    endtask

    initial begin
        int d0;
        int lows;
        rst = 1'b1; clear = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        stall_en = 1'b0; stall_period = 8'd0; stall_len = 8'd0;
        cyc(3);
        chk("rst_tready", 512'(s_axis_tready), 512'd1);
        chk("rst_pkt_cnt", 512'(pkt_cnt), 512'd0);
        chk("rst_byte_cnt", 512'(byte_cnt), 512'd0);
        chk("rst_err_flags", 512'(err_flags), 512'd0);
        chk("rst_pkt_done", 512'(pkt_done), 512'd0);
        chk("rst_first_beat", first_beat, 512'd0);
        rst = 1'b0;
        cyc(1);

        // Four full beats
        for (int i = 0; i < 4; i++) send(mk(32'h100 + i), '1, 128'hAAA0 + 128'(i), i == 3);
        chk("p1_done", 512'(pkt_done), 512'd1);
        chk("p1_bytes", 512'(pkt_bytes), 512'd256);
        idle(1);
        chk("p1_done_pulse", 512'(pkt_done), 512'd0);
        chk("p1_pkt_cnt", 512'(pkt_cnt), 512'd1);
        chk("p1_beat_cnt", 512'(beat_cnt), 512'd4);
        chk("p1_byte_cnt", 512'(byte_cnt), 512'd256);
        chk("p1_first_beat", first_beat, mk(32'h100));
        chk("p1_first_tuser", 512'(first_tuser), 512'h0AAA0);
        chk("p1_done_seen", 512'(done_seen), 512'd1);

        // Short last beat: 64 + 64 + 16 bytes
        send(mk(32'h200), '1, 128'hBBB0, 1'b0);
        send(mk(32'h201), '1, 128'hBBB1, 1'b0);
        send(mk(32'h202), 64'h0000_0000_0000_FFFF, 128'hBBB2, 1'b1);
        chk("p2_bytes", 512'(pkt_bytes), 512'd144);
        chk("p2_err_flags", 512'(err_flags), 512'd0);
        idle(1);
        chk("p2_pkt_cnt", 512'(pkt_cnt), 512'd2);
        chk("p2_byte_cnt", 512'(byte_cnt), 512'd400);
        chk("p2_first_beat", first_beat, mk(32'h200));
        chk("p2_first_tuser", 512'(first_tuser), 512'h0BBB0);

        // Mid-packet tkeep 0x5: non-contiguous and short
        send(mk(32'h300), '1, 128'hCCC0, 1'b0);
        send(mk(32'h301), 64'h5, 128'hCCC1, 1'b0);
        send(mk(32'h302), '1, 128'hCCC2, 1'b1);
        chk("p3_done", 512'(pkt_done), 512'd1);
        chk("p3_bytes", 512'(pkt_bytes), 512'd130);
        idle(1);
        chk("p3_err_flags", 512'(err_flags), 512'h3);
        chk("p3_err_cnt", 512'(err_cnt), 512'd1);
        chk("p3_pkt_cnt", 512'(pkt_cnt), 512'd2);
        chk("p3_first_beat", first_beat, mk(32'h200));
        chk("p3_beat_cnt", 512'(beat_cnt), 512'd10);
        chk("p3_byte_cnt", 512'(byte_cnt), 512'd530);

        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clr_pkt_cnt", 512'(pkt_cnt), 512'd0);
        chk("clr_beat_cnt", 512'(beat_cnt), 512'd0);
        chk("clr_byte_cnt", 512'(byte_cnt), 512'd0);
        chk("clr_err_cnt", 512'(err_cnt), 512'd0);
        chk("clr_err_flags", 512'(err_flags), 512'd0);
        chk("clr_first_beat", first_beat, mk(32'h200));

        // 70 beats: oversize, drops after beat 64
        d0 = done_seen;
        for (int i = 0; i < 70; i++) send(mk(32'h400 + i), '1, 128'hDDD0, i == 69);
        chk("ovr_done", 512'(pkt_done), 512'd0);
        idle(2);
        chk("ovr_done_seen", 512'(done_seen), 512'(d0));
        chk("ovr_err_flags", 512'(err_flags), 512'h8);
        chk("ovr_err_cnt", 512'(err_cnt), 512'd1);
        chk("ovr_pkt_cnt", 512'(pkt_cnt), 512'd0);
        chk("ovr_beat_cnt", 512'(beat_cnt), 512'd70);
        chk("ovr_byte_cnt", 512'(byte_cnt), 512'd4480);

        // Exactly 64 beats with tlast on the last one is legal
        for (int i = 0; i < 64; i++) send(mk(32'h500 + i), '1, 128'hEEE0, i == 63);
        chk("max_done", 512'(pkt_done), 512'd1);
        chk("max_bytes", 512'(pkt_bytes), 512'd4096);
        idle(1);
        chk("max_pkt_cnt", 512'(pkt_cnt), 512'd1);
        chk("max_err_cnt", 512'(err_cnt), 512'd1);
        chk("max_beat_cnt", 512'(beat_cnt), 512'd134);
        chk("max_byte_cnt", 512'(byte_cnt), 512'd8576);
        chk("max_first_beat", first_beat, mk(32'h500));

        clear = 1'b1; cyc(1); clear = 1'b0;

        // Backpressure 1-in-4 with a held-valid source, two back-to-back packets
        stall_en = 1'b1; stall_period = 8'd4; stall_len = 8'd1;
        d0 = done_seen;
        for (int i = 0; i < 8; i++) send(mk(32'h600 + i), '1, 128'hF000 + 128'(i), (i % 4) == 3);
        idle(2);
        chk("bp_pkt_cnt", 512'(pkt_cnt), 512'd2);
        chk("bp_beat_cnt", 512'(beat_cnt), 512'd8);
        chk("bp_byte_cnt", 512'(byte_cnt), 512'd512);
        chk("bp_err_cnt", 512'(err_cnt), 512'd0);
        chk("bp_first_beat", first_beat, mk(32'h604));
        chk("bp_first_tuser", 512'(first_tuser), 512'h0F004);
        chk("bp_done_seen", 512'(done_seen - d0), 512'd2);
        lows = 0;
        repeat (16) begin
            if (!s_axis_tready) lows++;
            cyc(1);
        end
        chk("bp_low_cycles", 512'(lows), 512'd4);

        // stall_len >= stall_period holds tready low
        stall_len = 8'd5;
        cyc(2);
        lows = 0;
        repeat (8) begin
            if (!s_axis_tready) lows++;
            cyc(1);
        end
        chk("bp_hold_low", 512'(lows), 512'd8);
        stall_en = 1'b0;
        cyc(2);
        chk("bp_release", 512'(s_axis_tready), 512'd1);

        // Reset in the middle of a packet discards it
        send(mk(32'h700), '1, 128'h7770, 1'b0);
        send(mk(32'h701), '1, 128'h7771, 1'b0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("mrst_pkt_cnt", 512'(pkt_cnt), 512'd0);
        send(mk(32'h702), 64'hFF, 128'h7772, 1'b1);
        chk("mrst_done", 512'(pkt_done), 512'd1);
        chk("mrst_bytes", 512'(pkt_bytes), 512'd8);
        idle(2);
        chk("mrst_pkt_cnt_after", 512'(pkt_cnt), 512'd1);
        chk("mrst_done_seen", 512'(done_seen), 512'd1);
        chk("mrst_err_flags", 512'(err_flags), 512'd0);
        chk("mrst_first_beat", first_beat, mk(32'h702));
        chk("mrst_first_tuser", 512'(first_tuser), 512'h07772);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
